// File: rtl/ece571_cpu_pipe.sv
// ece571_cpu_pipe: two-stage ALU pipeline with an internal register file.
// RD latches an issued instruction; operands are selected and the ALU result
// is computed as RD advances into EX. EX holds the result for the consumer
// and writes it back to the register file on retire. A host port can preload
// registers at any time. A retire write to the same register on the same edge
// takes priority over a host write.
module ece571_cpu_pipe #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [AW-1:0]     in_rs1,
  input  logic [AW-1:0]     in_rs2,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_wen,
  input  logic              host_we,
  input  logic [AW-1:0]     host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [AW-1:0]     out_rd,
  output logic              out_zero
);

  localparam int SW = $clog2(DATA_W);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  logic [DATA_W-1:0] regs [NREGS];

  // RD stage: instruction fields waiting for operand read
  logic          rd_valid;
  logic [2:0]    rd_op;
  logic [AW-1:0] rd_rs1;
  logic [AW-1:0] rd_rs2;
  logic [AW-1:0] rd_rd;
  logic          rd_wen;

  // EX stage: computed result waiting for the consumer
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic [AW-1:0]     ex_rd;
  logic              ex_wen;
  logic              ex_zero;

  logic              ex_adv;
  logic              rd_adv;
  logic              retire;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [SW-1:0]     shamt;
  logic [DATA_W-1:0] alu_res;

  assign ex_adv   = !ex_valid || out_ready;
  assign rd_adv   = rd_valid && ex_adv;
  assign retire   = ex_valid && out_ready;
  // Held low during reset so the issuer cannot push into a clearing pipe.
  assign in_ready = !reset && (!rd_valid || rd_adv);

  assign out_valid  = ex_valid;
  assign out_result = ex_result;
  assign out_rd     = ex_rd;
  assign out_zero   = ex_zero;

  // Operand A: newest value wins -- EX result, then same-edge host write, then regfile
  always_comb begin
    opa = regs[rd_rs1];
    if (host_we && (host_waddr == rd_rs1)) begin
      opa = host_wdata;
    end
    if (ex_valid && ex_wen && (ex_rd == rd_rs1)) begin
      opa = ex_result;
    end
  end

  // Operand B: same priority as operand A
  always_comb begin
    opb = regs[rd_rs2];
    if (host_we && (host_waddr == rd_rs2)) begin
      opb = host_wdata;
    end
    if (ex_valid && ex_wen && (ex_rd == rd_rs2)) begin
      opb = ex_result;
    end
  end

  assign shamt = opb[SW-1:0];

  // ALU: all arithmetic wraps modulo 2^DATA_W; shifts use only the low SW bits of b
  always_comb begin
    alu_res = '0;
    case (rd_op)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa) < $signed(opb))};
      default: alu_res = '0;
    endcase
  end

  // RD stage register: accept a new instruction whenever the slot is free or draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_op    <= '0;
      rd_rs1   <= '0;
      rd_rs2   <= '0;
      rd_rd    <= '0;
      rd_wen   <= 1'b0;
    end else if (in_ready) begin
      rd_valid <= in_valid;
      if (in_valid) begin
        rd_op  <= in_op;
        rd_rs1 <= in_rs1;
        rd_rs2 <= in_rs2;
        rd_rd  <= in_rd;
        rd_wen <= in_wen;
      end
    end
  end

  // EX stage register: capture the ALU result as RD advances, hold while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_result <= '0;
      ex_rd     <= '0;
      ex_wen    <= 1'b0;
      ex_zero   <= 1'b1;
    end else if (ex_adv) begin
      ex_valid <= rd_valid;
      if (rd_valid) begin
        ex_result <= alu_res;
        ex_rd     <= rd_rd;
        ex_wen    <= rd_wen;
        ex_zero   <= (alu_res == '0);
      end
    end
  end

  // Register file: retire writeback beats a host write to the same register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (retire && ex_wen && (ex_rd == AW'(i))) begin
          regs[i] <= ex_result;
        end else if (host_we && (host_waddr == AW'(i))) begin
          regs[i] <= host_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ece571_cpu_pipe.sv
// Directed bench for ece571_cpu_pipe (DATA_W=32, NREGS=16).
// Stimulus changes on the falling edge; a retire monitor samples 2ns after the
// falling edge and compares each retiring result against an expected queue
// filled at issue time with hand-computed values.
module tb_ece571_cpu_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SLL = 3'd5, SRL = 3'd6, SLT = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_wen = 1'b0;
  logic        host_we = 1'b0;
  logic [3:0]  host_waddr = '0;
  logic [31:0] host_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_zero;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rd;
  } exp_t;
  exp_t exp_q[$];

  int errs = 0;
  int checks = 0;

  ece571_cpu_pipe #(.DATA_W(32), .NREGS(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Retire monitor: a result retires at the next rising edge when valid && ready
  always begin
    @(negedge clk);
    #2;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("ret_spurious", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ret_result", out_result, e.res);
        chk("ret_rd", 32'(out_rd), 32'(e.rd));
        chk("ret_zero", 32'(out_zero), 32'(e.res == 32'd0));
      end
    end
  end

  // Issue one instruction starting at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input logic [2:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic wen, input logic [31:0] exp);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wen = wen;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      e.res = exp;
      e.rd = rd;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic host_load(input logic [3:0] a, input logic [31:0] d);
    host_we = 1'b1; host_waddr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // Observe a register by passing it through OR with itself, no writeback
  task automatic read_reg(input logic [3:0] r, input logic [31:0] exp);
    issue(OR_, r, r, 4'd0, 1'b0, exp);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Basic op and latency
    host_load(4'd1, 32'd5);
    host_load(4'd2, 32'd7);
    issue(ADD, 4'd1, 4'd2, 4'd3, 1'b1, 32'd12);
    chk("lat_edgeN_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edgeN1_valid", 32'(out_valid), 32'd1);
    chk("lat_result", out_result, 32'd12);
    chk("lat_rd", 32'(out_rd), 32'd3);
    chk("lat_zero", 32'(out_zero), 32'd0);
    drain();
    read_reg(4'd3, 32'd12);

    // Back-to-back forwarding
    issue(ADD, 4'd1, 4'd2, 4'd3, 1'b1, 32'd12);
    issue(SUB, 4'd3, 4'd1, 4'd4, 1'b1, 32'd7);
    issue(XOR_, 4'd4, 4'd4, 4'd5, 1'b1, 32'd0);
    drain();
    read_reg(4'd4, 32'd7);

    // Backpressure
    out_ready = 1'b0;
    issue(ADD, 4'd1, 4'd1, 4'd8, 1'b1, 32'd10);
    issue(ADD, 4'd8, 4'd2, 4'd9, 1'b1, 32'd17);
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_result", out_result, 32'd10);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();
    read_reg(4'd9, 32'd17);

    // Write conflict: retire and host write hit r6 on the same edge
    host_load(4'd11, 32'hAAAA0000);
    out_ready = 1'b0;
    issue(OR_, 4'd11, 4'd11, 4'd6, 1'b1, 32'hAAAA0000);
    @(negedge clk);
    chk("wc_held", 32'(out_valid), 32'd1);
    host_we = 1'b1; host_waddr = 4'd6; host_wdata = 32'h1234;
    out_ready = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    drain();
    read_reg(4'd6, 32'hAAAA0000);

    // Retire to r10 and host write to r7 on the same edge both land
    out_ready = 1'b0;
    issue(OR_, 4'd11, 4'd11, 4'd10, 1'b1, 32'hAAAA0000);
    @(negedge clk);
    host_we = 1'b1; host_waddr = 4'd7; host_wdata = 32'h55;
    out_ready = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    drain();
    read_reg(4'd7, 32'h55);
    read_reg(4'd10, 32'hAAAA0000);

    // Shift / compare edge cases
    host_load(4'd12, 32'd1);
    host_load(4'd13, 32'd33);
    host_load(4'd14, 32'h80000000);
    host_load(4'd15, 32'd31);
    host_load(4'd9, 32'hFFFFFFFF);
    issue(SLL, 4'd12, 4'd13, 4'd1, 1'b0, 32'd2);
    issue(SRL, 4'd14, 4'd15, 4'd1, 1'b0, 32'd1);
    issue(SLT, 4'd9, 4'd12, 4'd1, 1'b0, 32'd1);
    issue(SLT, 4'd12, 4'd9, 4'd1, 1'b0, 32'd0);
    issue(SUB, 4'd0, 4'd12, 4'd1, 1'b0, 32'hFFFFFFFF);
    issue(AND_, 4'd9, 4'd14, 4'd2, 1'b0, 32'h80000000);
    drain();

    // Host write forwarded into an operand read on the same edge
    issue(ADD, 4'd12, 4'd0, 4'd2, 1'b0, 32'd100);
    host_we = 1'b1; host_waddr = 4'd12; host_wdata = 32'd100;
    @(negedge clk);
    host_we = 1'b0;
    drain();

    // Reset with two instructions in flight
    read_reg(4'd1, 32'd5);
    issue(ADD, 4'd1, 4'd1, 4'd1, 1'b1, 32'd10);
    issue(ADD, 4'd2, 4'd2, 4'd2, 1'b1, 32'd14);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_release_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_retire", 32'(out_valid), 32'd0);
    read_reg(4'd1, 32'd0);
    read_reg(4'd2, 32'd0);
    read_reg(4'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
